// File: rtl/relu_issue_seq.sv
// relu_issue_seq
// Streams an M x N FP32 matrix into an external ReLU engine one element at a
// time (AWR), kicks the engine (START), polls its status (STAT) until it is
// idle, then reads every result back (YRD) and presents it on the y stream.
// This block only sequences instructions; element data passes through as-is.
//
// Optional build macro: RELU_ISSUE_SEQ_TIMEOUT_EN
//   When defined, POLL_WAIT and RD_WAIT give up after TIMEOUT cycles without a
//   matching writeback and park in ERR with job_err set until reset.
//   When undefined, the wait states wait forever and job_err is tied low.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   job_start                     start one M*N job (ignored unless idle)
//   job_busy, job_done, job_err   in progress / end pulse / sticky timeout
//   x_valid, x_ready, x_data      input element stream, row-major
//   y_valid, y_ready, y_data      output element stream
//   y_row, y_col                  indices of the element on y_data
//   instr_valid, instr_ready      instruction request handshake
//   instr, rs1_val, rs2_val       R-type word and operands
//   rd_addr                       destination register of the request
//   rd_we, rd_waddr, rd_wdata     engine writeback
//
// State     | meaning
// IDLE      | waiting for job_start
// LOAD      | accepting x elements, one AWR per element
// START     | issuing START
// POLL      | issuing STAT
// POLL_WAIT | waiting for the STAT writeback (register 1)
// RD        | issuing YRD for the current element
// RD_WAIT   | waiting for the YRD writeback (register 2)
// OUT       | presenting the element on y until accepted
// DONE      | one-cycle job_done pulse
// ERR       | writeback timed out, parked until reset (macro builds only)

module relu_issue_seq #(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_err,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic [15:0]       y_row,
  output logic [15:0]       y_col,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       rs1_val,
  output logic [31:0]       rs2_val,
  output logic [4:0]        rd_addr,
  input  logic              rd_we,
  input  logic [4:0]        rd_waddr,
  input  logic [31:0]       rd_wdata
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    START,
    POLL,
    POLL_WAIT,
    RD,
    RD_WAIT,
    OUT,
    DONE
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  localparam logic [2:0] F_AWR   = 3'b000;
  localparam logic [2:0] F_START = 3'b001;
  localparam logic [2:0] F_STAT  = 3'b010;
  localparam logic [2:0] F_YRD   = 3'b011;

  localparam logic [4:0] REG_NONE = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_YRD  = 5'd2;

  function automatic logic [31:0] rtype_word(input logic [2:0] funct3);
    return {7'h03, 10'd0, funct3, 5'd0, 7'h33};
  endfunction

  state_t      state;
  logic [15:0] row;
  logic [15:0] col;
  logic        last_col;
  logic        last_elem;

  assign last_col  = (col == 16'(N - 1));
  assign last_elem = last_col && (row == 16'(M - 1));

  // x is only accepted while no AWR is waiting, so one x beat maps to one AWR.
  assign x_ready  = (state == LOAD) && !instr_valid;
  assign job_busy = (state != IDLE);

`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_tc;

  // Down-counter loaded on entry to a wait state; terminal count at zero.
  assign wait_tc = (wait_cnt == '0);
`else
  assign job_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      rd_addr     <= '0;
      y_valid     <= 1'b0;
      y_data      <= '0;
      y_row       <= '0;
      y_col       <= '0;
      job_done    <= 1'b0;
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      job_err     <= 1'b0;
`endif
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (job_start) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
          end
        end

        LOAD: begin
          if (instr_valid) begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              if (last_elem) begin
                state <= START;
              end else if (last_col) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end
          end else if (x_valid) begin
            instr_valid <= 1'b1;
            instr       <= rtype_word(F_AWR);
            rs1_val     <= {row, col};
            rs2_val     <= 32'(x_data);
            rd_addr     <= REG_NONE;
          end
        end

        START: begin
          if (instr_valid) begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              state       <= POLL;
            end
          end else begin
            instr_valid <= 1'b1;
            instr       <= rtype_word(F_START);
            rs1_val     <= '0;
            rs2_val     <= '0;
            rd_addr     <= REG_NONE;
          end
        end

        POLL: begin
          if (instr_valid) begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              state       <= POLL_WAIT;
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
              wait_cnt    <= TW'(TIMEOUT - 1);
`endif
            end
          end else begin
            instr_valid <= 1'b1;
            instr       <= rtype_word(F_STAT);
            rs1_val     <= '0;
            rs2_val     <= '0;
            rd_addr     <= REG_STAT;
          end
        end

        POLL_WAIT: begin
          if (rd_we && (rd_waddr == REG_STAT)) begin
            // Bit 1 of the status word is the engine busy flag.
            if (rd_wdata[1]) begin
              state <= POLL;
            end else begin
              state <= RD;
              row   <= '0;
              col   <= '0;
            end
          end
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
          else if (wait_tc) begin
            state   <= ERR;
            job_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
`endif
        end

        RD: begin
          if (instr_valid) begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              state       <= RD_WAIT;
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
              wait_cnt    <= TW'(TIMEOUT - 1);
`endif
            end
          end else begin
            instr_valid <= 1'b1;
            instr       <= rtype_word(F_YRD);
            rs1_val     <= {row, col};
            rs2_val     <= '0;
            rd_addr     <= REG_YRD;
          end
        end

        RD_WAIT: begin
          if (rd_we && (rd_waddr == REG_YRD)) begin
            y_data  <= DATA_W'(rd_wdata);
            y_row   <= row;
            y_col   <= col;
            y_valid <= 1'b1;
            state   <= OUT;
          end
`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
          else if (wait_tc) begin
            state   <= ERR;
            job_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
`endif
        end

        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (last_elem) begin
              state    <= DONE;
              job_done <= 1'b1;
            end else begin
              state <= RD;
              if (last_col) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
        ERR: begin
          state <= ERR;
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_issue_seq.sv
`timescale 1ns/1ps
module tb_relu_issue_seq;
  localparam int M  = 8;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NE = M * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_start = 1'b0;
  logic          job_busy, job_done, job_err;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [DW-1:0] x_data = '0;
  logic          y_valid;
  logic          y_ready = 1'b0;
  logic [DW-1:0] y_data;
  logic [15:0]   y_row, y_col;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr, rs1_val, rs2_val;
  logic [4:0]    rd_addr;
  logic          rd_we = 1'b0;
  logic [4:0]    rd_waddr = '0;
  logic [31:0]   rd_wdata = '0;

  relu_issue_seq #(.M(M), .N(N), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row), .y_col(y_col),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata)
  );

  always #5 clk = ~clk;

  // Element pattern with hand-computed ReLU results.
  typedef struct {
    logic [31:0] x;
    logic [31:0] y_exp;
  } vec_t;
  vec_t tbl[8];

  // Per-job environment settings and expected STAT count.
  typedef struct {
    int awr_stall;
    int y_div;
    int busy_n;
    bit stray;
    bit poke;
    int exp_stat;
  } job_t;
  job_t jobs[3];

  int checks = 0;
  int failures = 0;

  // Environment / engine model state
  int awr_stall, y_div, busy_n;
  bit stray_en, stat_silent, x_en;
  int awr_count, start_count, stat_count, stat_resp, yrd_count, out_count, done_count;
  int x_idx, stall_cnt, y_tick, resp_dly;
  bit x_acc, resp_pend, hold_seen, y_seen;
  logic [4:0]   resp_addr;
  logic [31:0]  resp_data;
  logic [100:0] hold_lat;
  logic [63:0]  y_lat;
  logic [31:0]  mem[NE];

  function automatic logic [31:0] rw(input logic [2:0] f3);
    return {7'h03, 10'd0, f3, 5'd0, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reset_model();
    awr_count = 0; start_count = 0; stat_count = 0; stat_resp = 0;
    yrd_count = 0; out_count = 0; done_count = 0;
    x_idx = 0; stall_cnt = 0; y_tick = 0; resp_dly = 0;
    x_acc = 0; resp_pend = 0; hold_seen = 0; y_seen = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, {instr_valid, x_ready, y_valid, job_busy, job_done, job_err}, '0);
    chk({tag, "_instr"}, {instr, rs1_val, rs2_val, rd_addr}, '0);
    chk({tag, "_y"}, {y_data, y_row, y_col}, '0);
  endtask

  // Environment: x source, y sink and ReLU engine model, all acting on the
  // falling edge for the following rising edge.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (rst) begin
        x_valid = 0; instr_ready = 0; y_ready = 0;
        rd_we = 0; rd_waddr = '0; rd_wdata = '0;
        x_acc = 0; resp_pend = 0; hold_seen = 0; y_seen = 0; stall_cnt = 0;
      end else begin
        // x source
        if (x_acc) begin x_idx++; x_acc = 0; end
        x_valid = x_en && (x_idx < NE);
        x_data  = tbl[x_idx % 8].x;
        if (x_valid && x_ready) x_acc = 1;

        if (job_done) done_count++;

        // engine writeback
        rd_we = 0; rd_waddr = '0; rd_wdata = '0;
        if (resp_pend) begin
          if (resp_dly == 0) begin
            rd_we = 1; rd_waddr = resp_addr; rd_wdata = resp_data;
            resp_pend = 0;
            if (resp_addr == 5'd1) stat_resp++;
          end else begin
            if (resp_dly == 1 && stray_en) begin
              rd_we = 1; rd_waddr = resp_addr ^ 5'h3; rd_wdata = '1;
            end
            resp_dly--;
          end
        end

        // engine instruction port
        instr_ready = 0;
        if (instr_valid) begin
          if (hold_seen) chk("instr_hold", {instr, rs1_val, rs2_val, rd_addr}, hold_lat);
          else begin hold_lat = {instr, rs1_val, rs2_val, rd_addr}; hold_seen = 1; end
          if (instr[14:12] == 3'b000 && stall_cnt < awr_stall) begin
            stall_cnt++;
          end else begin
            instr_ready = 1; hold_seen = 0; stall_cnt = 0;
            case (instr[14:12])
              3'b000: begin
                k = awr_count;
                chk("awr", {instr, rs1_val, rs2_val, 27'd0, rd_addr},
                    {rw(3'b000), 16'(k / N), 16'(k % N), tbl[k % 8].x, 27'd0, 5'd0});
                mem[k % NE] = rs2_val;
                awr_count++;
              end
              3'b001: begin
                chk("start", {instr, rs1_val, rs2_val, 27'd0, rd_addr}, {rw(3'b001), 96'd0});
                chk("start_after_awr", awr_count, NE);
                start_count++;
              end
              3'b010: begin
                chk("stat", {instr, rs1_val, rs2_val, 27'd0, rd_addr},
                    {rw(3'b010), 64'd0, 27'd0, 5'd1});
                stat_count++;
                if (!stat_silent) begin
                  resp_pend = 1; resp_dly = 2; resp_addr = 5'd1;
                  resp_data = (stat_count <= busy_n) ? 32'h2 : 32'h0;
                end
              end
              3'b011: begin
                k = yrd_count;
                chk("yrd", {instr, rs1_val, rs2_val, 27'd0, rd_addr},
                    {rw(3'b011), 16'(k / N), 16'(k % N), 32'd0, 27'd0, 5'd2});
                if (k == 0) chk("first_yrd_stat", {stat_count, stat_resp}, {busy_n + 1, busy_n + 1});
                resp_pend = 1; resp_dly = 2; resp_addr = 5'd2;
                resp_data = mem[k % NE][31] ? 32'h0 : mem[k % NE];
                yrd_count++;
              end
              default: chk("instr_funct", instr, rw(3'b000));
            endcase
          end
        end

        // y sink
        y_ready = 0;
        if (y_valid) begin
          if (y_seen) chk("y_hold", {y_data, y_row, y_col}, y_lat);
          else begin y_lat = {y_data, y_row, y_col}; y_seen = 1; end
          y_tick++;
          if (y_tick % y_div == 0) begin
            y_ready = 1; k = out_count;
            chk("y_out", {y_data, y_row, y_col}, {tbl[k % 8].y_exp, 16'(k / N), 16'(k % N)});
            out_count++; y_seen = 0;
          end
        end
      end
    end
  end

  task automatic run_job(input bit poke, output bit ok);
    bit poked;
    @(posedge clk); #1 job_start = 1;
    @(posedge clk); #1 job_start = 0;
    ok = 0; poked = 0;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk); #1;
      job_start = poke && !poked && (awr_count == 10);
      if (job_start) poked = 1;
      if (done_count != 0) begin ok = 1; break; end
    end
    job_start = 0;
  endtask

  task automatic check_job(input string tag, input int exp_stat);
    chk({tag, "_awr_n"}, awr_count, NE);
    chk({tag, "_start_n"}, start_count, 1);
    chk({tag, "_stat_n"}, stat_count, exp_stat);
    chk({tag, "_yrd_n"}, yrd_count, NE);
    chk({tag, "_out_n"}, out_count, NE);
    chk({tag, "_done_n"}, done_count, 1);
    chk({tag, "_idle"}, {job_busy, job_err, instr_valid, y_valid}, 4'b0000);
  endtask

  initial begin
    bit ok;
    tbl[0] = '{32'hBF800000, 32'h00000000};
    tbl[1] = '{32'h3F800000, 32'h3F800000};
    tbl[2] = '{32'h80000000, 32'h00000000};
    tbl[3] = '{32'h00000000, 32'h00000000};
    tbl[4] = '{32'hC1200000, 32'h00000000};
    tbl[5] = '{32'h40000000, 32'h40000000};
    tbl[6] = '{32'hC0000000, 32'h00000000};
    tbl[7] = '{32'h40400000, 32'h40400000};
    //          stall ydiv busy stray poke stat
    jobs[0] = '{0,    1,   0,   0,    0,   1};
    jobs[1] = '{0,    1,   3,   1,    1,   4};
    jobs[2] = '{5,    3,   1,   1,    0,   2};

    reset_model();
    x_en = 0; stat_silent = 0; stray_en = 0; awr_stall = 0; y_div = 1; busy_n = 0;

    rst = 1;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_init");
    rst = 0;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", {job_busy, x_ready, instr_valid, job_done}, 4'b0000);

    for (int j = 0; j < 3; j++) begin
      awr_stall = jobs[j].awr_stall; y_div = jobs[j].y_div;
      busy_n = jobs[j].busy_n; stray_en = jobs[j].stray;
      reset_model(); x_en = 1;
      run_job(jobs[j].poke, ok);
      chk($sformatf("j%0d_finished", j), ok, 1);
      repeat (4) @(posedge clk);
      #1 check_job($sformatf("j%0d", j), jobs[j].exp_stat);
    end

    // Reset in the middle of the load phase, then a clean job.
    awr_stall = 0; y_div = 1; busy_n = 0; stray_en = 0;
    reset_model(); x_en = 1;
    @(posedge clk); #1 job_start = 1;
    @(posedge clk); #1 job_start = 0;
    for (int n = 0; n < 500 && awr_count < 20; n++) begin
      @(posedge clk); #1;
    end
    chk("mid_awr_reached", awr_count, 20);
    rst = 1;
    @(posedge clk);
    #1 check_reset_vals("rst_mid");
    @(posedge clk);
    #1 reset_model();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 chk("post_rst_idle", {job_busy, x_ready, instr_valid}, 3'b000);
    run_job(0, ok);
    chk("post_rst_finished", ok, 1);
    repeat (4) @(posedge clk);
    #1 check_job("post_rst", 1);

`ifdef RELU_ISSUE_SEQ_TIMEOUT_EN
    begin
      int n;
      reset_model(); stat_silent = 1; x_en = 1;
      @(posedge clk); #1 job_start = 1;
      @(posedge clk); #1 job_start = 0;
      for (int c = 0; c < 2000 && stat_count == 0; c++) begin
        @(posedge clk); #1;
      end
      chk("to_stat_issued", stat_count, 1);
      n = 0;
      for (int c = 0; c < 40 && !job_err; c++) begin
        @(posedge clk); #1; n++;
      end
      chk("to_err_set", job_err, 1);
      chk("to_within_17", n <= 17, 1);
      repeat (5) @(posedge clk);
      #1 chk("to_sticky_busy", {job_err, job_busy}, 2'b11);
      chk("to_no_done", done_count, 0);
      rst = 1;
      @(posedge clk);
      #1 check_reset_vals("to_rst");
      rst = 0; stat_silent = 0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
